// File: rtl/pipeline_drain_stage.sv
// Drain stage: show-ahead FIFO between a stall-capable pipeline and a valid/ready consumer.
// Optional running checksum enabled by defining PIPELINE_DRAIN_CHECKSUM_EN.
module pipeline_drain_stage #(
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH),
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      in_data,
  input  logic             in_valid,
  input  logic             in_flush,
  output logic             out_stall,
  output logic [31:0]      rd_data,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic [AW:0]      level,
  output logic [CNT_W-1:0] word_count,
  output logic [31:0]      checksum
);

  logic [31:0]      mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg, wr_ptr_next;
  logic [AW-1:0]    rd_ptr_reg, rd_ptr_next;
  logic [AW:0]      level_reg, level_next;
  logic [CNT_W-1:0] count_reg;
  logic             push, pop;

  // Stall depends only on the registered level so upstream sees no combinational loop.
  assign out_stall = (level_reg == (AW+1)'(DEPTH));
  assign rd_valid  = (level_reg != '0) & ~in_flush;
  assign rd_data   = mem[rd_ptr_reg];
  assign push      = in_valid & ~out_stall & ~in_flush;
  assign pop       = rd_valid & rd_ready;

  assign level      = level_reg;
  assign word_count = count_reg;

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    level_next  = level_reg;
    if (in_flush) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      level_next  = '0;
    end else begin
      if (push) wr_ptr_next = wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_next = rd_ptr_reg + 1'b1;
      case ({push, pop})
        2'b10:   level_next = level_reg + 1'b1;
        2'b01:   level_next = level_reg - 1'b1;
        default: level_next = level_reg;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
      count_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      level_reg  <= level_next;
      if (push) count_reg <= count_reg + 1'b1;
    end
  end

  // Storage has no reset so it can map onto distributed RAM.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= in_data;
  end

`ifdef PIPELINE_DRAIN_CHECKSUM_EN
  logic [31:0] checksum_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      checksum_reg <= '0;
    end else if (in_flush) begin
      checksum_reg <= '0;
    end else if (push) begin
      checksum_reg <= {checksum_reg[30:0], checksum_reg[31]} ^ in_data;
    end
  end

  assign checksum = checksum_reg;
`else
  assign checksum = 32'h0;
`endif

endmodule

// File: tb/tb_pipeline_drain_stage.sv
// Directed test of pipeline_drain_stage (DEPTH=4) with hand-computed expectations.
module tb_pipeline_drain_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_flush;
  logic        out_stall;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        rd_ready;
  logic [2:0]  level;
  logic [15:0] word_count;
  logic [31:0] checksum;

  int checks = 0;
  int errors = 0;

  pipeline_drain_stage #(.DEPTH(4), .CNT_W(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_flush   (in_flush),
    .out_stall  (out_stall),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .rd_ready   (rd_ready),
    .level      (level),
    .word_count (word_count),
    .checksum   (checksum)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    reset    = 1'b1;
    in_data  = '0;
    in_valid = 1'b0;
    in_flush = 1'b0;
    rd_ready = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    settle();

    // Idle after reset
    for (int i = 0; i < 10; i++) begin
      check("idle_rd_valid", 32'(rd_valid), 32'd0);
      check("idle_stall", 32'(out_stall), 32'd0);
      check("idle_level", 32'(level), 32'd0);
      check("idle_count", 32'(word_count), 32'd0);
      $display("idle cycle %0d level=%0d", i, level);
      tick();
    end

    // Fill to full
    for (int i = 0; i < 4; i++) begin
      in_data  = 32'hA0 + 32'(i);
      in_valid = 1'b1;
      tick();
      $display("push 0x%08h level=%0d", 32'hA0 + 32'(i), level);
    end
    check("full_level", 32'(level), 32'd4);
    check("full_stall", 32'(out_stall), 32'd1);
    check("full_head", rd_data, 32'hA0);
    in_data = 32'hA4;
    tick();
    check("blocked_level", 32'(level), 32'd4);
    check("blocked_count", 32'(word_count), 32'd4);

    // Single pop while full: push stays blocked this cycle
    rd_ready = 1'b1;
    settle();
    check("pop_valid", 32'(rd_valid), 32'd1);
    check("pop_data", rd_data, 32'hA0);
    tick();
    rd_ready = 1'b0;
    settle();
    $display("pop 0x000000a0 level=%0d", level);
    check("after_pop_level", 32'(level), 32'd3);
    check("after_pop_stall", 32'(out_stall), 32'd0);
    tick();
    in_valid = 1'b0;
    check("a4_level", 32'(level), 32'd4);
    check("a4_count", 32'(word_count), 32'd5);

    // Drain in order
    rd_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      settle();
      check("drain_valid", 32'(rd_valid), 32'd1);
      check("drain_data", rd_data, 32'hA0 + 32'(i));
      $display("pop 0x%08h", rd_data);
      tick();
    end
    rd_ready = 1'b0;
    check("drained_level", 32'(level), 32'd0);
    check("drained_valid", 32'(rd_valid), 32'd0);

    // Level 2 then simultaneous push/pop across pointer wrap
    in_valid = 1'b1;
    in_data = 32'hB0; tick();
    in_data = 32'hB1; tick();
    check("lvl2_level", 32'(level), 32'd2);
    rd_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      logic [31:0] exp;
      exp = (i == 0) ? 32'hB0 : (i == 1) ? 32'hB1 : 32'h10 + 32'(i - 2);
      in_data = 32'h10 + 32'(i);
      settle();
      check("pp_data", rd_data, exp);
      $display("push 0x%08h pop 0x%08h", in_data, rd_data);
      tick();
      check("pp_level", 32'(level), 32'd2);
    end
    rd_ready = 1'b0;
    check("pp_count", 32'(word_count), 32'd15);
    check("pp_head", rd_data, 32'h16);

    // Level 3, then flush
    in_data = 32'h20; tick();
    check("pre_flush_level", 32'(level), 32'd3);
    in_data  = 32'h30;
    in_flush = 1'b1;
    rd_ready = 1'b1;
    settle();
    check("flush_rd_valid", 32'(rd_valid), 32'd0);
    tick();
    in_flush = 1'b0;
    in_valid = 1'b0;
    rd_ready = 1'b0;
    settle();
    $display("flush level=%0d count=%0d", level, word_count);
    check("flush_level", 32'(level), 32'd0);
    check("flush_count", 32'(word_count), 32'd16);
    check("flush_valid_after", 32'(rd_valid), 32'd0);
    check("flush_stall", 32'(out_stall), 32'd0);
    check("flush_checksum", checksum, 32'h0);
    in_valid = 1'b1; in_data = 32'h40; tick();
    in_valid = 1'b0;
    check("post_flush_valid", 32'(rd_valid), 32'd1);
    check("post_flush_data", rd_data, 32'h40);
    check("post_flush_level", 32'(level), 32'd1);

    // Asynchronous reset mid-operation
    reset = 1'b1;
    settle();
    check("areset_level", 32'(level), 32'd0);
    check("areset_count", 32'(word_count), 32'd0);
    check("areset_valid", 32'(rd_valid), 32'd0);
    tick();
    reset = 1'b0;
    settle();

    // Checksum sequence
    in_valid = 1'b1;
    in_data = 32'h00000001; tick();
`ifdef PIPELINE_DRAIN_CHECKSUM_EN
    check("cks_1", checksum, 32'h00000001);
`else
    check("cks_off_1", checksum, 32'h0);
`endif
    in_data = 32'h00000002; tick();
    check("cks_2", checksum, 32'h00000000);
    in_data = 32'hFFFF0000; tick();
    in_valid = 1'b0;
`ifdef PIPELINE_DRAIN_CHECKSUM_EN
    check("cks_3", checksum, 32'hFFFF0000);
`else
    check("cks_off_3", checksum, 32'h0);
`endif
    $display("checksum 0x%08h count=%0d", checksum, word_count);
    check("cks_count", 32'(word_count), 32'd3);
    check("cks_level", 32'(level), 32'd3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
